pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Pipeline sequencing controller for the 5-stage core. It generates the per-stage stall vector that freezes the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It sequences multi-cycle EX operations (multiply-accumulate, divide) through a counter FSM. It also arbitrates between ID load-use stall requests, EX multi-cycle stalls and pipeline flush requests, and keeps a saturating stall-cycle performance counter.

Parameters:
MADD_CYCLES, 2, EX busy cycles for a multiply-accumulate op (must be >= 1)
DIV_CYCLES, 32, EX busy cycles for a divide op (must be >= 1)
CNT_W, 6, width of the busy counter (must hold max(MADD_CYCLES, DIV_CYCLES) - 1)
PERF_W, 16, width of the stall performance counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
stallreq_id  input  1  load-use hazard detected in ID
ex_start  input  1  EX holds a multi-cycle op this cycle; sampled only in IDLE
ex_kind  input  1  0 = multiply-accumulate, 1 = divide; sampled with ex_start
flush_req  input  1  exception/redirect flush request
stall  output  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB (1 = hold)
flush  output  1  clear the IF/ID, ID/EX, EX/MEM and MEM/WB registers this cycle
ex_busy  output  1  multi-cycle op in progress
ex_done  output  1  one-cycle pulse: EX result valid, pipeline advances
ex_cnt  output  CNT_W  remaining busy cycles
stall_cycles  output  PERF_W  saturating count of cycles with stall[0]=1

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, ex_cnt=0, stall_cycles=0. While rst=0: stall=6'b000000, flush=0, ex_busy=0, ex_done=0, all combinationally forced.
- FSM states: IDLE, BUSY, DONE (registered).
- IDLE:
  - If ex_start=1 and flush_req=0: load ex_cnt <= (ex_kind ? DIV_CYCLES : MADD_CYCLES) - 1, then go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - If flush_req=1: go to IDLE and set ex_cnt <= 0.
  - Else if ex_cnt==0: go to DONE.
  - Else: decrement ex_cnt.
- DONE: always go to IDLE next cycle. ex_start is ignored in BUSY and DONE.
- Latency: an op started in cycle T is in BUSY for cycles T+1..T+N, DONE in T+N+1 (N = op cycles). Stall is held for cycles T..T+N (N+1 cycles).
- Output priority (combinational, first match wins):
  1. flush_req=1: flush=1, stall=000000. This also aborts BUSY and suppresses a same-cycle ex_start.
  2. state==BUSY, or (state==IDLE and ex_start=1): stall=001111 (PC, IF, ID and EX held; MEM and WB drain).
  3. stallreq_id=1: stall=000111, including during DONE.
  4. Otherwise: stall=000000.
- ex_busy=1 iff state==BUSY. ex_done=1 iff state==DONE; stall bit3 is 0 in DONE.
- stall_cycles: increments on each rising edge where stall[0]=1. Saturates at all-ones with no wrap.
- ex_kind and ex_start are ignored when not in IDLE. Re-entry into BUSY requires a fresh ex_start in IDLE.
- Reset asserted during BUSY: immediate return to IDLE, no ex_done pulse.

Test Plan:
- Reset, idle inputs -> stall=000000, flush=0, ex_busy=0, stall_cycles=0. Release rst, 5 cycles -> no change.
- stallreq_id=1 for 3 cycles -> stall=000111 for exactly those 3 cycles, stall_cycles=3.
- ex_start=1, ex_kind=0 at T (MADD_CYCLES=2) -> stall=001111 at T..T+2, ex_busy at T+1..T+2, ex_done only at T+3, ex_cnt 1,0.
- ex_start=1, ex_kind=1 at T -> ex_cnt=31 at T+1 counting to 0 at T+32, ex_done at T+33, stall_cycles += 33.
- Divide started, flush_req=1 at T+10 -> flush=1 and stall=000000 at T+10, state IDLE at T+11, no ex_done. ex_start together with flush_req -> ignored.
- rst=0 asserted mid-BUSY -> outputs cleared immediately. stall_cycles forced saturating (PERF_W=4, 20 stall cycles) -> holds at 15.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: per-stage stall vector, multi-cycle EX
// sequencing (MADD/DIV), flush arbitration and a saturating stall counter.
module pipe_ctrl #(
    parameter int MADD_CYCLES = 2,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6,
    parameter int PERF_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_id,
    input  logic              ex_start,
    input  logic              ex_kind,
    input  logic              flush_req,
    output logic [5:0]        stall,
    output logic              flush,
    output logic              ex_busy,
    output logic              ex_done,
    output logic [CNT_W-1:0]  ex_cnt,
    output logic [PERF_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0]  MADD_LOAD  = CNT_W'(MADD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  DIV_LOAD   = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [PERF_W-1:0] PERF_ZERO  = {PERF_W{1'b0}};
    localparam logic [PERF_W-1:0] PERF_ONE   = PERF_W'(1);
    localparam logic [PERF_W-1:0] PERF_MAX   = {PERF_W{1'b1}};
    localparam logic [5:0]        STALL_NONE = 6'b000000;
    localparam logic [5:0]        STALL_EX   = 6'b001111;
    localparam logic [5:0]        STALL_ID   = 6'b000111;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PERF_W-1:0] perf_q, perf_d;
    logic [5:0]        stall_s;
    logic              flush_s;
    logic              busy_s;
    logic              done_s;

    // Next-state and busy-counter logic for the multi-cycle EX sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (ex_start && !flush_req) begin
                    cnt_d   = ex_kind ? DIV_LOAD : MADD_LOAD;
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (flush_req) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_ZERO) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Output arbitration: flush beats EX stall beats ID load-use stall;
    // everything is forced quiet while reset is held.
    always_comb begin
        stall_s = STALL_NONE;
        flush_s = 1'b0;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        if (!rst) begin
            stall_s = STALL_NONE;
        end else begin
            busy_s = (state_q == ST_BUSY);
            done_s = (state_q == ST_DONE);
            if (flush_req) begin
                flush_s = 1'b1;
                stall_s = STALL_NONE;
            end else if ((state_q == ST_BUSY) || ((state_q == ST_IDLE) && ex_start)) begin
                stall_s = STALL_EX;
            end else if (stallreq_id) begin
                stall_s = STALL_ID;
            end else begin
                stall_s = STALL_NONE;
            end
        end
    end

    // Saturating count of cycles in which the PC is held.
    always_comb begin
        perf_d = perf_q;
        if (stall_s[0] && (perf_q != PERF_MAX)) begin
            perf_d = perf_q + PERF_ONE;
        end else begin
            perf_d = perf_q;
        end
    end

    // State, busy counter and performance counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            perf_q  <= PERF_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            perf_q  <= perf_d;
        end
    end

    assign stall        = stall_s;
    assign flush        = flush_s;
    assign ex_busy      = busy_s;
    assign ex_done      = done_s;
    assign ex_cnt       = cnt_q;
    assign stall_cycles = perf_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; a second instance with a
// 4-bit stall counter shares the stimulus to exercise saturation.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallreq_id = 1'b0;
    logic        ex_start = 1'b0;
    logic        ex_kind = 1'b0;
    logic        flush_req = 1'b0;
    logic [5:0]  stall;
    logic        flush;
    logic        ex_busy;
    logic        ex_done;
    logic [5:0]  ex_cnt;
    logic [15:0] stall_cycles;
    logic [5:0]  s_stall;
    logic        s_flush;
    logic        s_busy;
    logic        s_done;
    logic [5:0]  s_cnt;
    logic [3:0]  s_cycles;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.MADD_CYCLES(2), .DIV_CYCLES(32), .CNT_W(6), .PERF_W(16)) dut (
        .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_start(ex_start),
        .ex_kind(ex_kind), .flush_req(flush_req), .stall(stall), .flush(flush),
        .ex_busy(ex_busy), .ex_done(ex_done), .ex_cnt(ex_cnt), .stall_cycles(stall_cycles)
    );

    pipe_ctrl #(.MADD_CYCLES(2), .DIV_CYCLES(32), .CNT_W(6), .PERF_W(4)) dut_sat (
        .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_start(ex_start),
        .ex_kind(ex_kind), .flush_req(flush_req), .stall(s_stall), .flush(s_flush),
        .ex_busy(s_busy), .ex_done(s_done), .ex_cnt(s_cnt), .stall_cycles(s_cycles)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sr, input logic st, input logic kd, input logic fl);
        stallreq_id = sr;
        ex_start    = st;
        ex_kind     = kd;
        flush_req   = fl;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        #1 rst = 1'b0;
        tick();
        tick();
        #2;
        n_chk++; if (stall !== 6'b000000) begin n_fail++; $display("FAIL reset_stall got=%b exp=000000", stall); end
        n_chk++; if (flush !== 1'b0 || ex_busy !== 1'b0 || ex_done !== 1'b0) begin n_fail++; $display("FAIL reset_ctl got=%b%b%b exp=000", flush, ex_busy, ex_done); end
        n_chk++; if (ex_cnt !== 6'd0 || stall_cycles !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", ex_cnt, stall_cycles); end
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_chk++; if (stall !== 6'b000000 || ex_busy !== 1'b0 || stall_cycles !== 16'd0) begin n_fail++; $display("FAIL idle_after_reset got=%b/%b/%0d exp=000000/0/0", stall, ex_busy, stall_cycles); end
            tick();
        end
    endtask

    task automatic test_stallreq();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++; if (stall !== 6'b000111) begin n_fail++; $display("FAIL stallreq_stall got=%b exp=000111", stall); end
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_chk++; if (stall !== 6'b000000) begin n_fail++; $display("FAIL stallreq_release got=%b exp=000000", stall); end
        n_chk++; if (stall_cycles !== 16'd3 || s_cycles !== 4'd3) begin n_fail++; $display("FAIL stallreq_perf got=%0d/%0d exp=3/3", stall_cycles, s_cycles); end
        tick();
    endtask

    task automatic test_madd();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        n_chk++; if (stall !== 6'b001111 || ex_busy !== 1'b0 || ex_done !== 1'b0) begin n_fail++; $display("FAIL madd_T got=%b/%b/%b exp=001111/0/0", stall, ex_busy, ex_done); end
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            n_chk++; if (stall !== 6'b001111 || ex_busy !== 1'b1 || ex_done !== 1'b0 || ex_cnt !== 6'(2 - i)) begin
                n_fail++; $display("FAIL madd_busy%0d got=%b/%b/%b/%0d exp=001111/1/0/%0d", i, stall, ex_busy, ex_done, ex_cnt, 2 - i);
            end
            tick();
        end
        @(negedge clk);
        n_chk++; if (ex_done !== 1'b1 || ex_busy !== 1'b0 || stall !== 6'b000000) begin n_fail++; $display("FAIL madd_done got=%b/%b/%b exp=1/0/000000", ex_done, ex_busy, stall); end
        tick();
        @(negedge clk);
        n_chk++; if (ex_done !== 1'b0 || stall_cycles !== 16'd6 || s_cycles !== 4'd6) begin n_fail++; $display("FAIL madd_after got=%b/%0d/%0d exp=0/6/6", ex_done, stall_cycles, s_cycles); end
        tick();
    endtask

    task automatic test_div();
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        n_chk++; if (stall !== 6'b001111) begin n_fail++; $display("FAIL div_T got=%b exp=001111", stall); end
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 32; i++) begin
            // ex_start/ex_kind mid-op must be ignored
            if (i == 5) drive(1'b0, 1'b1, 1'b0, 1'b0); else drive(1'b0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            n_chk++; if (ex_busy !== 1'b1 || ex_cnt !== 6'(32 - i) || stall !== 6'b001111) begin
                n_fail++; $display("FAIL div_busy%0d got=%b/%0d/%b exp=1/%0d/001111", i, ex_busy, ex_cnt, stall, 32 - i);
            end
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_chk++; if (ex_done !== 1'b1 || ex_busy !== 1'b0) begin n_fail++; $display("FAIL div_done got=%b/%b exp=1/0", ex_done, ex_busy); end
        tick();
        @(negedge clk);
        n_chk++; if (stall_cycles !== 16'd39) begin n_fail++; $display("FAIL div_perf got=%0d exp=39", stall_cycles); end
        n_chk++; if (s_cycles !== 4'd15) begin n_fail++; $display("FAIL perf_saturate got=%0d exp=15", s_cycles); end
        n_chk++; if (ex_done !== 1'b0 || ex_busy !== 1'b0) begin n_fail++; $display("FAIL div_idle got=%b/%b exp=0/0", ex_done, ex_busy); end
        tick();
    endtask

    task automatic test_flush();
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 10; i++) tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        n_chk++; if (flush !== 1'b1 || stall !== 6'b000000 || ex_busy !== 1'b1 || ex_cnt !== 6'd22) begin
            n_fail++; $display("FAIL flush_T10 got=%b/%b/%b/%0d exp=1/000000/1/22", flush, stall, ex_busy, ex_cnt);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_chk++; if (flush !== 1'b0 || ex_busy !== 1'b0 || ex_done !== 1'b0 || ex_cnt !== 6'd0 || stall !== 6'b000000) begin
                n_fail++; $display("FAIL flush_abort%0d got=%b/%b/%b/%0d/%b exp=0/0/0/0/000000", i, flush, ex_busy, ex_done, ex_cnt, stall);
            end
            tick();
        end
        n_chk++; if (stall_cycles !== 16'd49 || s_cycles !== 4'd15) begin n_fail++; $display("FAIL flush_perf got=%0d/%0d exp=49/15", stall_cycles, s_cycles); end
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        n_chk++; if (flush !== 1'b1 || stall !== 6'b000000) begin n_fail++; $display("FAIL flush_start got=%b/%b exp=1/000000", flush, stall); end
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_chk++; if (ex_busy !== 1'b0 || ex_cnt !== 6'd0 || stall_cycles !== 16'd49) begin n_fail++; $display("FAIL flush_start_ignored got=%b/%0d/%0d exp=0/0/49", ex_busy, ex_cnt, stall_cycles); end
        tick();
    endtask

    task automatic test_stall_in_done();
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_chk++; if (stall !== 6'b001111) begin n_fail++; $display("FAIL busy_over_id got=%b exp=001111", stall); end
        tick();
        tick();
        @(negedge clk);
        n_chk++; if (ex_done !== 1'b1 || stall !== 6'b000111) begin n_fail++; $display("FAIL done_id_stall got=%b/%b exp=1/000111", ex_done, stall); end
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_chk++; if (stall_cycles !== 16'd53) begin n_fail++; $display("FAIL done_perf got=%0d exp=53", stall_cycles); end
        tick();
    endtask

    task automatic test_reset_mid_busy();
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_chk++; if (stall !== 6'b000000 || ex_busy !== 1'b0 || ex_done !== 1'b0 || flush !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_out got=%b/%b/%b/%b exp=000000/0/0/0", stall, ex_busy, ex_done, flush);
        end
        n_chk++; if (ex_cnt !== 6'd0 || stall_cycles !== 16'd0 || s_cycles !== 4'd0) begin
            n_fail++; $display("FAIL rst_mid_cnt got=%0d/%0d/%0d exp=0/0/0", ex_cnt, stall_cycles, s_cycles);
        end
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++; if (ex_busy !== 1'b0 || ex_done !== 1'b0 || stall !== 6'b000000) begin
                n_fail++; $display("FAIL rst_mid_after%0d got=%b/%b/%b exp=0/0/000000", i, ex_busy, ex_done, stall);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_stallreq();
        test_madd();
        test_div();
        test_flush();
        test_stall_in_done();
        test_reset_mid_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
